hamming_link_ctrl: RTL and testbench

- Sequencer and arbiter for the Hamming(12,8) encode / error-inject / decode datapath.
- Two requesters (slave channel 0, slave channel 1) share one datapath. The block round-robin arbitrates between them and latches the 8-bit message.
- It pulses the datapath encode strobe with an optional single-bit error injection, waits out the decode latency, then returns corrected data plus syndrome to the granted channel's result registers.

---
 rtl/hamming_link_ctrl.sv | 170 +++++++++++++++++
 tb/tb_hamming_link_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/hamming_link_ctrl.sv
// Two-channel round-robin sequencer for the Hamming(12,8) encode / inject / decode datapath.
// One transaction at a time: grant + encode strobe, wait out decode latency, capture, done pulse.
module hamming_link_ctrl #(
  parameter int unsigned DEC_LAT = 2,
  parameter int unsigned POS_MAX = 11
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic       req1,
  input  logic [7:0] msg0,
  input  logic [7:0] msg1,
  input  logic       inj0,
  input  logic       inj1,
  output logic       gnt0,
  output logic       gnt1,
  output logic [7:0] enc_data,
  output logic       enc_strobe,
  output logic       inj_en,
  output logic [3:0] inj_pos,
  input  logic [7:0] dec_data,
  input  logic [3:0] dec_syndrome,
  output logic       done0,
  output logic       done1,
  output logic [7:0] rslt0,
  output logic [7:0] rslt1,
  output logic [3:0] synd0,
  output logic [3:0] synd1,
  output logic       err0,
  output logic       err1,
  output logic       busy
);

  localparam logic [3:0] LAT     = 4'(DEC_LAT);
  localparam logic [3:0] PMAX    = 4'(POS_MAX);
  localparam logic [4:0] ERR_THR = 5'(POS_MAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ENC  = 2'd1,
    ST_WAIT = 2'd2,
    ST_CAPT = 2'd3
  } state_t;

  state_t      state_reg;
  state_t      state_next;
  logic        ch_reg;
  logic        last_reg;
  logic [7:0]  msg_reg;
  logic        inj_reg;
  logic [3:0]  wait_reg;
  logic [3:0]  pos_reg;
  logic        win_ch;
  logic        start;
  logic        capture;

  logic [7:0]  rslt_reg [2];
  logic [3:0]  synd_reg [2];
  logic        err_reg  [2];

  // On a tie the channel not granted last wins; otherwise the sole requester.
  assign win_ch  = (req0 && req1) ? ~last_reg : req1;
  assign start   = (state_reg == ST_IDLE) && (req0 || req1);
  assign capture = (state_reg == ST_WAIT) && (wait_reg == 4'd1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_IDLE: if (req0 || req1) state_next = ST_ENC;
      ST_ENC:  state_next = ST_WAIT;
      ST_WAIT: if (wait_reg == 4'd1) state_next = ST_CAPT;
      ST_CAPT: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    enc_strobe = 1'b0;
    enc_data   = 8'd0;
    inj_en     = 1'b0;
    done0      = 1'b0;
    done1      = 1'b0;
    busy       = (state_reg != ST_IDLE);
    unique case (state_reg)
      ST_ENC: begin
        gnt0       = ~ch_reg;
        gnt1       = ch_reg;
        enc_strobe = 1'b1;
        enc_data   = msg_reg;
        inj_en     = inj_reg;
      end
      ST_CAPT: begin
        done0 = ~ch_reg;
        done1 = ch_reg;
      end
      default: ;
    endcase
  end

  assign inj_pos = pos_reg;

  // Transaction context: winner, message and injection request frozen at grant.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ch_reg   <= 1'b0;
      last_reg <= 1'b1;
      msg_reg  <= 8'd0;
      inj_reg  <= 1'b0;
    end else if (start) begin
      ch_reg   <= win_ch;
      last_reg <= win_ch;
      msg_reg  <= win_ch ? msg1 : msg0;
      inj_reg  <= win_ch ? inj1 : inj0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_reg <= 4'd0;
    end else if (state_reg == ST_ENC) begin
      wait_reg <= LAT;
    end else if (state_reg == ST_WAIT) begin
      wait_reg <= wait_reg - 4'd1;
    end
  end

  // Injection position only moves after an encode that actually flipped a bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pos_reg <= 4'd0;
    end else if ((state_reg == ST_ENC) && inj_reg) begin
      pos_reg <= (pos_reg >= PMAX) ? 4'd0 : pos_reg + 4'd1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chan
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          rslt_reg[gi] <= 8'd0;
          synd_reg[gi] <= 4'd0;
          err_reg[gi]  <= 1'b0;
        end else if (capture && (ch_reg == 1'(gi))) begin
          rslt_reg[gi] <= dec_data;
          synd_reg[gi] <= dec_syndrome;
          err_reg[gi]  <= ({1'b0, dec_syndrome} > ERR_THR);
        end
      end
    end
  endgenerate

  assign rslt0 = rslt_reg[0];
  assign rslt1 = rslt_reg[1];
  assign synd0 = synd_reg[0];
  assign synd1 = synd_reg[1];
  assign err0  = err_reg[0];
  assign err1  = err_reg[1];

endmodule

// File: tb/tb_hamming_link_ctrl.sv
// Directed bench for hamming_link_ctrl: the bench plays both requesters and the decode datapath.
module tb_hamming_link_ctrl;

  localparam int DEC_LAT = 2;
  localparam int POS_MAX = 11;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0, req1, inj0, inj1;
  logic [7:0] msg0, msg1, dec_data;
  logic [3:0] dec_syndrome;
  logic       gnt0, gnt1, enc_strobe, inj_en, done0, done1, err0, err1, busy;
  logic [7:0] enc_data, rslt0, rslt1;
  logic [3:0] inj_pos, synd0, synd1;

  int n_chk  = 0;
  int n_pass = 0;

  hamming_link_ctrl #(.DEC_LAT(DEC_LAT), .POS_MAX(POS_MAX)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .msg0(msg0), .msg1(msg1), .inj0(inj0), .inj1(inj1),
    .gnt0(gnt0), .gnt1(gnt1), .enc_data(enc_data), .enc_strobe(enc_strobe),
    .inj_en(inj_en), .inj_pos(inj_pos), .dec_data(dec_data), .dec_syndrome(dec_syndrome),
    .done0(done0), .done1(done1), .rslt0(rslt0), .rslt1(rslt1),
    .synd0(synd0), .synd1(synd1), .err0(err0), .err1(err1), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One full transaction on channel ch; expected values are supplied by the caller.
  task automatic txn(input bit ch, input logic [7:0] msg, input bit inj,
                     input logic [7:0] ddata, input logic [3:0] dsynd,
                     input logic [3:0] exp_pos, input bit exp_err);
    logic [7:0] o_rslt;
    logic [3:0] o_synd;
    logic       o_err;
    int         n;
    bit         got;
    o_rslt = ch ? rslt0 : rslt1;
    o_synd = ch ? synd0 : synd1;
    o_err  = ch ? err0  : err1;
    if (ch) begin req1 = 1'b1; msg1 = msg; inj1 = inj; end
    else    begin req0 = 1'b1; msg0 = msg; inj0 = inj; end
    dec_data = ddata;
    dec_syndrome = dsynd;
    got = 1'b0;
    n = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick;
      n++;
      got = ch ? gnt1 : gnt0;
    end
    chk("gnt_seen", 32'(got), 1);
    if (!got) return;
    chk("gnt_lat", n, 1);
    chk("enc_strobe", 32'(enc_strobe), 1);
    chk("enc_data", 32'(enc_data), 32'(msg));
    chk("inj_en", 32'(inj_en), 32'(inj));
    chk("inj_pos", 32'(inj_pos), 32'(exp_pos));
    chk("gnt_other", 32'(ch ? gnt0 : gnt1), 0);
    // Drop the request and disturb the inputs; the running transaction must not notice.
    if (ch) begin req1 = 1'b0; msg1 = ~msg; inj1 = ~inj; end
    else    begin req0 = 1'b0; msg0 = ~msg; inj0 = ~inj; end
    got = 1'b0;
    n = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick;
      n++;
      got = ch ? done1 : done0;
    end
    chk("done_seen", 32'(got), 1);
    if (!got) return;
    chk("done_lat", n, DEC_LAT + 1);
    chk("done_other", 32'(ch ? done0 : done1), 0);
    chk("rslt", 32'(ch ? rslt1 : rslt0), 32'(ddata));
    chk("synd", 32'(ch ? synd1 : synd0), 32'(dsynd));
    chk("err", 32'(ch ? err1 : err0), 32'(exp_err));
    chk("rslt_other", 32'(ch ? rslt0 : rslt1), 32'(o_rslt));
    chk("synd_other", 32'(ch ? synd0 : synd1), 32'(o_synd));
    chk("err_other", 32'(ch ? err0 : err1), 32'(o_err));
    $display("txn ch=%0d msg=%02h inj=%0d pos=%0d rslt=%02h synd=%0h err=%0d",
             ch, msg, inj, inj_pos, ch ? rslt1 : rslt0, ch ? synd1 : synd0, ch ? err1 : err0);
    tick;
    chk("idle_busy", 32'(busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int gcnt0, dcnt0, dcnt1, ph, c;
    reset = 1'b0;
    req0 = 0; req1 = 0; inj0 = 0; inj1 = 0;
    msg0 = 0; msg1 = 0; dec_data = 0; dec_syndrome = 0;
    tick; tick;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_gnt", 32'({gnt0, gnt1, enc_strobe, inj_en, done0, done1}), 0);
    chk("rst_pos", 32'(inj_pos), 0);
    chk("rst_rslt", 32'({rslt0, rslt1, synd0, synd1, err0, err1}), 0);
    reset = 1'b1;

    // Basic channel 0 round, no injection.
    txn(1'b0, 8'hA5, 1'b0, 8'hA5, 4'h0, 4'd0, 1'b0);
    chk("t1_rslt1", 32'(rslt1), 0);

    // Thirteen injected rounds on channel 1: positions 0..11 then wrap to 0.
    for (int i = 0; i < 13; i++)
      txn(1'b1, 8'(8'h30 + i), 1'b1, 8'(8'h30 + i), 4'(i), 4'(i % 12), 1'b0);

    // Both channels held: grants alternate 0,1,0,1 every DEC_LAT+3 cycles.
    req0 = 1; req1 = 1; msg0 = 8'h11; msg1 = 8'h22; inj0 = 0; inj1 = 0;
    dec_data = 8'h5A; dec_syndrome = 4'h0;
    for (int t = 1; t <= 20; t++) begin
      tick;
      ph = (t - 1) % 5;
      c  = ((t - 1) / 5) % 2;
      chk("rr_gnt0", 32'(gnt0), 32'(ph == 0 && c == 0));
      chk("rr_gnt1", 32'(gnt1), 32'(ph == 0 && c == 1));
      chk("rr_done0", 32'(done0), 32'(ph == 3 && c == 0));
      chk("rr_done1", 32'(done1), 32'(ph == 3 && c == 1));
      chk("rr_busy", 32'(busy), 32'(ph != 4));
      if (ph == 0) begin
        chk("rr_enc_data", 32'(enc_data), (c == 1) ? 32'h22 : 32'h11);
        chk("rr_inj_pos", 32'(inj_pos), 1);
        $display("txn rr ch=%0d enc_data=%02h", c, enc_data);
      end
      if (t == 20) begin req0 = 0; req1 = 0; end
    end

    // Syndrome above POS_MAX+1 flags err; the next in-range syndrome clears it.
    txn(1'b0, 8'h0F, 1'b0, 8'hF0, 4'hE, 4'd1, 1'b1);
    txn(1'b0, 8'h0F, 1'b0, 8'h0F, 4'h5, 4'd1, 1'b0);

    // Abort a channel 0 round during WAIT with an asynchronous reset.
    req0 = 1; msg0 = 8'h77; inj0 = 1; dec_data = 8'h77; dec_syndrome = 4'h0;
    tick;
    chk("ab_gnt0", 32'(gnt0), 1);
    chk("ab_pos", 32'(inj_pos), 1);
    req0 = 0;
    tick;
    chk("ab_busy", 32'(busy), 1);
    #2 reset = 1'b0;
    #1;
    chk("ab_rst_busy", 32'(busy), 0);
    chk("ab_rst_pos", 32'(inj_pos), 0);
    chk("ab_rst_rslt", 32'({rslt0, rslt1, synd0, synd1, err0, err1}), 0);
    chk("ab_rst_ctl", 32'({gnt0, gnt1, enc_strobe, inj_en, done0, done1, enc_data}), 0);
    tick;
    reset = 1'b1;
    dcnt0 = 0;
    for (int t = 0; t < 6; t++) begin
      tick;
      if (done0) dcnt0++;
    end
    chk("ab_no_done0", dcnt0, 0);
    req1 = 1; msg1 = 8'hC3; inj1 = 0;
    txn(1'b0, 8'h3C, 1'b1, 8'h3C, 4'h0, 4'd0, 1'b0);
    txn(1'b1, 8'hC3, 1'b0, 8'hC3, 4'h3, 4'd1, 1'b0);

    // A one-cycle req0 pulse while channel 1 is in WAIT is never granted.
    req1 = 1; msg1 = 8'h99; inj1 = 0; dec_data = 8'h99; dec_syndrome = 4'h0;
    gcnt0 = 0; dcnt0 = 0; dcnt1 = 0;
    for (int t = 1; t <= 15; t++) begin
      tick;
      if (t == 1) req1 = 0;
      if (t == 2) req0 = 1;
      if (t == 3) req0 = 0;
      if (gnt0) gcnt0++;
      if (done0) dcnt0++;
      if (done1) dcnt1++;
    end
    chk("pulse_gnt0", gcnt0, 0);
    chk("pulse_done0", dcnt0, 0);
    chk("pulse_done1", dcnt1, 1);
    chk("pulse_rslt1", 32'(rslt1), 32'h99);
    $display("txn pulse ch=1 rslt=%02h gnt0_count=%0d", rslt1, gcnt0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
